// File: rtl/key_direction_queue.sv
// Snake-game key front end: synchronises and debounces four direction keys, filters
// reversal/duplicate requests and buffers accepted turns until the next game step.

`ifndef UP_DIR
`define UP_DIR    2'b00
`endif
`ifndef DOWN_DIR
`define DOWN_DIR  2'b01
`endif
`ifndef LEFT_DIR
`define LEFT_DIR  2'b10
`endif
`ifndef RIGHT_DIR
`define RIGHT_DIR 2'b11
`endif

module key_direction_queue #(
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned QUEUE_DEPTH     = 4,
   parameter logic [1:0]  INIT_DIR        = `LEFT_DIR
) (
   input  logic                               i_clock,
   input  logic                               i_reset,
   input  logic [3:0]                         i_key,
   input  logic                               i_tick,
   output logic                               o_game_start,
   output logic [1:0]                         o_direction,
   output logic [$clog2(QUEUE_DEPTH+1)-1:0]   o_queue_count,
   output logic                               o_overflow
);

   localparam int unsigned CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int unsigned PTR_W   = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
   localparam int unsigned COUNT_W = $clog2(QUEUE_DEPTH + 1);

   localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [PTR_W-1:0]   PTR_LAST   = PTR_W'(QUEUE_DEPTH - 1);
   localparam logic [COUNT_W-1:0] COUNT_FULL = COUNT_W'(QUEUE_DEPTH);

   // Synchroniser chains, one 4-bit slice per stage
   logic [SYNC_STAGES-1:0][3:0] sync_q, sync_d;
   logic [3:0]                  key_sync;

   // Debounce state
   logic [3:0][CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]            stable_q, stable_d;
   logic [3:0]            stable_prev_q, stable_prev_d;

   // Press decode and request filtering
   logic [3:0] rise;
   logic       press_valid;
   logic [1:0] req_dir;
   logic [1:0] tail_dir;
   logic [1:0] tail_rev;
   logic       accept;

   // Queue state
   logic [1:0]         mem_q [QUEUE_DEPTH];
   logic [1:0]         mem_d [QUEUE_DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]   tail_ptr;
   logic [COUNT_W-1:0] count_q, count_d;
   logic               q_empty, q_full;
   logic               push, pop, drop;

   // Committed outputs
   logic [1:0] dir_q, dir_d;
   logic       game_start_q, game_start_d;
   logic       overflow_q, overflow_d;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
   endfunction

   // ---------------------------------------------------------------------------
   // Synchroniser
   // ---------------------------------------------------------------------------
   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], i_key};
   end

   assign key_sync = sync_q[SYNC_STAGES-1];

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         sync_q <= '0;
      end else begin
         sync_q <= sync_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Debounce: stable bit flips only after DEBOUNCE_CYCLES consecutive differing cycles
   // ---------------------------------------------------------------------------
   always_comb begin
      cnt_d         = cnt_q;
      stable_d      = stable_q;
      stable_prev_d = stable_q;
      for (int k = 0; k < 4; k++) begin
         if (key_sync[k] == stable_q[k]) begin
            cnt_d[k] = '0;
         end else if (cnt_q[k] == CNT_LAST) begin
            stable_d[k] = key_sync[k];
            cnt_d[k]    = '0;
         end else begin
            cnt_d[k] = cnt_q[k] + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         cnt_q         <= '0;
         stable_q      <= '0;
         stable_prev_q <= '0;
      end else begin
         cnt_q         <= cnt_d;
         stable_q      <= stable_d;
         stable_prev_q <= stable_prev_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Press detection and request filter
   // ---------------------------------------------------------------------------
   assign rise        = stable_q & ~stable_prev_q;
   assign press_valid = $onehot(rise);

   always_comb begin
      req_dir = `UP_DIR;
      unique case (rise)
         4'b0001: req_dir = `RIGHT_DIR;
         4'b0010: req_dir = `LEFT_DIR;
         4'b0100: req_dir = `DOWN_DIR;
         4'b1000: req_dir = `UP_DIR;
         default: req_dir = `UP_DIR;
      endcase
   end

   assign q_empty  = (count_q == '0);
   assign q_full   = (count_q == COUNT_FULL);
   assign tail_ptr = (wr_ptr_q == '0) ? PTR_LAST : wr_ptr_q - PTR_W'(1);
   assign tail_dir = q_empty ? dir_q : mem_q[tail_ptr];
   // Encoding pairs opposites on bit 0
   assign tail_rev = {tail_dir[1], ~tail_dir[0]};
   assign accept   = press_valid && (req_dir != tail_dir) && (req_dir != tail_rev);

   // A full queue still accepts a push when the same cycle pops an entry
   assign pop  = i_tick && !q_empty;
   assign push = accept && (!q_full || pop);
   assign drop = accept && q_full && !pop;

   // ---------------------------------------------------------------------------
   // Queue next state
   // ---------------------------------------------------------------------------
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         mem_d[wr_ptr_q] = req_dir;
         wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (pop) begin
         rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + COUNT_W'(1);
         2'b01:   count_d = count_q - COUNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_comb begin
      dir_d        = pop ? mem_q[rd_ptr_q] : dir_q;
      game_start_d = game_start_q | press_valid;
      overflow_d   = overflow_q | drop;
   end

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         mem_q        <= '{default: '0};
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         dir_q        <= INIT_DIR;
         game_start_q <= 1'b0;
         overflow_q   <= 1'b0;
      end else begin
         mem_q        <= mem_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         dir_q        <= dir_d;
         game_start_q <= game_start_d;
         overflow_q   <= overflow_d;
      end
   end

   assign o_direction   = dir_q;
   assign o_game_start  = game_start_q;
   assign o_queue_count = count_q;
   assign o_overflow    = overflow_q;

endmodule

// File: tb/tb_key_direction_queue.sv
// Self-checking bench for key_direction_queue: scoreboard of expected committed directions
// plus a small model of count, game-start and overflow flags.

module tb_key_direction_queue;

   localparam logic [1:0] DIR_UP    = 2'b00;
   localparam logic [1:0] DIR_DOWN  = 2'b01;
   localparam logic [1:0] DIR_LEFT  = 2'b10;
   localparam logic [1:0] DIR_RIGHT = 2'b11;
   localparam int unsigned DEPTH    = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] key = 4'b0000;
   logic       tick = 1'b0;
   logic       game_start;
   logic [1:0] direction;
   logic [1:0] queue_count;
   logic       overflow;

   int checks   = 0;
   int failures = 0;

   logic [1:0] model_dir;
   logic       model_gs;
   logic       model_ovf;
   logic [1:0] exp_q[$];

   key_direction_queue #(
      .SYNC_STAGES     (2),
      .DEBOUNCE_CYCLES (4),
      .QUEUE_DEPTH     (DEPTH),
      .INIT_DIR        (DIR_LEFT)
   ) dut (
      .i_clock       (clk),
      .i_reset       (rst),
      .i_key         (key),
      .i_tick        (tick),
      .o_game_start  (game_start),
      .o_direction   (direction),
      .o_queue_count (queue_count),
      .o_overflow    (overflow)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic logic [1:0] dir_of(input logic [3:0] k);
      case (k)
         4'b0001: return DIR_RIGHT;
         4'b0010: return DIR_LEFT;
         4'b0100: return DIR_DOWN;
         default: return DIR_UP;
      endcase
   endfunction

   task automatic check_state(input string tag);
      check_eq({tag, "_dir"}, 32'(direction), 32'(model_dir));
      check_eq({tag, "_gs"}, 32'(game_start), 32'(model_gs));
      check_eq({tag, "_count"}, 32'(queue_count), 32'(exp_q.size()));
      check_eq({tag, "_ovf"}, 32'(overflow), 32'(model_ovf));
   endtask

   task automatic do_reset(input string tag);
      rst  = 1'b1;
      key  = 4'b0000;
      tick = 1'b0;
      #1;
      model_dir = DIR_LEFT;
      model_gs  = 1'b0;
      model_ovf = 1'b0;
      exp_q.delete();
      check_state(tag);
      step(2);
      check_state({tag, "_held"});
      rst = 1'b0;
      step(1);
   endtask

   // Hold a key long enough for the push, check, then release and let it settle
   task automatic press(input logic [3:0] k, input string tag);
      logic [1:0] req;
      logic [1:0] tail;
      key = k;
      step(7);
      req      = dir_of(k);
      tail     = (exp_q.size() != 0) ? exp_q[$] : model_dir;
      model_gs = 1'b1;
      if (req != tail && req != {tail[1], ~tail[0]}) begin
         if (exp_q.size() < DEPTH) exp_q.push_back(req);
         else model_ovf = 1'b1;
      end
      check_eq({tag, "_count"}, 32'(queue_count), 32'(exp_q.size()));
      check_eq({tag, "_gs"}, 32'(game_start), 32'(model_gs));
      check_eq({tag, "_ovf"}, 32'(overflow), 32'(model_ovf));
      step(2);
      key = 4'b0000;
      step(9);
   endtask

   task automatic do_tick(input string tag);
      tick = 1'b1;
      step(1);
      tick = 1'b0;
      if (exp_q.size() != 0) model_dir = exp_q.pop_front();
      check_eq({tag, "_dir"}, 32'(direction), 32'(model_dir));
      check_eq({tag, "_count"}, 32'(queue_count), 32'(exp_q.size()));
      check_eq({tag, "_ovf"}, 32'(overflow), 32'(model_ovf));
   endtask

   initial begin
      step(1);

      // Glitch shorter than the debounce window
      do_reset("rst_glitch");
      key = 4'b1000;
      step(3);
      key = 4'b0000;
      step(12);
      check_eq("glitch_gs", 32'(game_start), 32'(0));
      check_eq("glitch_count", 32'(queue_count), 32'(0));

      // Single press with exact latency, then commit
      do_reset("rst_single");
      key = 4'b1000;
      step(6);
      check_eq("lat_gs_early", 32'(game_start), 32'(0));
      check_eq("lat_count_early", 32'(queue_count), 32'(0));
      step(1);
      model_gs = 1'b1;
      exp_q.push_back(DIR_UP);
      check_eq("lat_gs", 32'(game_start), 32'(1));
      check_eq("lat_count", 32'(queue_count), 32'(exp_q.size()));
      key = 4'b0000;
      step(10);
      do_tick("single_tick");
      do_tick("empty_tick");

      // Reversal and duplicate filtering
      do_reset("rst_filter");
      press(4'b0001, "filt_right");
      press(4'b0010, "filt_left");
      press(4'b1000, "filt_up");
      press(4'b0100, "filt_down");
      do_tick("filt_tick");

      // Fill and overflow
      do_reset("rst_full");
      press(4'b1000, "full_up");
      press(4'b0001, "full_right");
      press(4'b0100, "full_down");
      do_tick("full_tick1");
      do_tick("full_tick2");

      // Simultaneous rises are ignored
      do_reset("rst_simul");
      key = 4'b1001;
      step(9);
      check_eq("simul_gs", 32'(game_start), 32'(0));
      check_eq("simul_count", 32'(queue_count), 32'(0));
      key = 4'b0000;
      step(9);

      // Push coinciding with a tick on an empty queue is not committed
      key = 4'b1000;
      step(6);
      tick = 1'b1;
      step(1);
      tick = 1'b0;
      model_gs = 1'b1;
      exp_q.push_back(DIR_UP);
      check_eq("pushtick_count", 32'(queue_count), 32'(exp_q.size()));
      check_eq("pushtick_dir", 32'(direction), 32'(model_dir));
      key = 4'b0000;
      step(9);
      do_tick("pushtick_tick");

      // Reset while the queue is full and a key is mid-debounce
      do_reset("rst_mid_pre");
      press(4'b1000, "mid_up");
      press(4'b0001, "mid_right");
      key = 4'b0100;
      step(4);
      do_reset("rst_mid");
      step(12);
      check_state("post_reset");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/key_direction_queue.md
# key_direction_queue

Parametrised key-input front end for the snake game, replacing the fixed single-register key decoder. It synchronises and debounces the four direction keys, turns clean presses into direction requests, rejects reversals and duplicates, and buffers accepted turns in a small FIFO. The movement engine consumes the FIFO one entry per game step. Multiple quick turns between two steps are therefore kept, not lost.

## Interface
Parameters:
- SYNC_STAGES, 2: flop stages per key synchroniser; legal range is 2 or more.
- DEBOUNCE_CYCLES, 4: consecutive cycles a synchronised key must differ from its stable value before the stable value flips; legal range is 1 or more.
- QUEUE_DEPTH, 4: number of pending direction entries; legal range is 1 or more.
- INIT_DIR, `LEFT_DIR: direction loaded at reset.

Ports:
- i_clock  in  1  system clock.
- i_reset  in  1  asynchronous, active-high reset.
- i_key  in  4  raw active-high keys, asynchronous. Bit 0 is right, bit 1 is left, bit 2 is down, bit 3 is up.
- i_tick  in  1  game-step strobe, one cycle wide. Commits and pops one queued direction.
- o_game_start  out  1  sticky flag, set on the first debounced key press.
- o_direction  out  2  committed direction, encoded with the shared UP/DOWN/LEFT/RIGHT_DIR macros.
- o_queue_count  out  $clog2(QUEUE_DEPTH+1)  number of pending entries.
- o_overflow  out  1  sticky flag, set when an accepted request is dropped because the queue is full.

## Operation
- **Synchroniser:** each key passes through a SYNC_STAGES flop chain. Every chain resets to 0.
- **Debounce:** each key has its own counter (width $clog2(DEBOUNCE_CYCLES), minimum 1) and a stable bit.
  - While the synchronised value equals the stable bit, the counter holds 0.
  - While they differ, the counter increments each cycle.
  - On a cycle where they differ and the counter equals DEBOUNCE_CYCLES-1, the stable bit takes the synchronised value and the counter clears.
  - A glitch that returns before that point clears the counter; the stable bit never changes.
- **Press event:** a stable bit rising 0→1, detected against a registered copy of the stable bits.
  - The event is valid only if exactly one key rises in that cycle.
  - Two or more keys rising in the same cycle are all ignored.
  - Key releases generate nothing.
- **o_game_start:** set on the cycle a valid press event is registered. This holds even if the request is later rejected. The flag stays set until reset.
- **Tail:** the last queue entry if the queue is non-empty, otherwise o_direction.
- **Request filter:** the request is rejected if it equals the tail or is the reverse of the tail (UP/DOWN, LEFT/RIGHT). Otherwise it is accepted.
- **Push:** an accepted request is pushed if o_queue_count < QUEUE_DEPTH. If the queue is full, the request is dropped and o_overflow is set.
- **Commit:** on i_tick with a non-empty queue, o_direction takes the head entry and the head pops. i_tick with an empty queue has no effect.
- **Push and pop in the same cycle:** both occur and the count is unchanged.
  - The tail is evaluated before the pop.
  - If the queue is empty, the pushed entry is not committed by that same tick.
  - If the queue is full, a simultaneous push and pop is allowed; it is not an overflow.
- **Storage:** circular buffer with read and write pointers that wrap modulo QUEUE_DEPTH. The count saturates at 0 and at QUEUE_DEPTH.

## Timing
- **Reset values:**
  - o_direction = INIT_DIR
  - o_game_start = 0
  - o_queue_count = 0
  - o_overflow = 0
  - all synchroniser flops, stable bits, counters and pointers = 0
- **Reset mid-operation:** reset discards any debounce in progress and all queued entries.
- **Press latency:** a key sampled high at edge 0 and held gives:
  - synchronised value at edge SYNC_STAGES;
  - stable bit high at edge SYNC_STAGES+DEBOUNCE_CYCLES;
  - push and o_game_start at edge SYNC_STAGES+DEBOUNCE_CYCLES+1.
- **Tick latency:** i_tick high in cycle n gives the new o_direction and decremented o_queue_count after edge n+1.
- All outputs are registered. The block has no combinational path from any input to any output.

## Test plan
Bench parameters: SYNC_STAGES=2, DEBOUNCE_CYCLES=4, QUEUE_DEPTH=2, INIT_DIR=LEFT.

1. **Reset, then single press.** Assert reset, then hold i_key=4'b1000 from edge 0. Required:
   - o_direction=LEFT, o_game_start=0, o_queue_count=0, o_overflow=0 during reset;
   - o_game_start=1 and o_queue_count=1 after edge 7.
   - Then pulse i_tick: o_direction=UP and o_queue_count=0 after the next edge.
2. **Glitch rejection.** Drive i_key[3] high for 3 cycles, then low. Required: no press event; o_game_start stays 0 and o_queue_count stays 0.
3. **Reversal and duplicate filter.** From LEFT:
   - press right → rejected, o_queue_count=0;
   - press left → rejected;
   - press up → accepted, count=1;
   - press down → rejected, because the tail is UP.
4. **Queue full and overflow.** From LEFT, press up, then right, then down. Required:
   - o_queue_count=2 and o_overflow=1 after the down press.
   - Two ticks give o_direction=UP, then RIGHT; the count goes 1, then 0; o_overflow stays 1.
5. **Simultaneous events.**
   - i_key[0] and i_key[3] rising in the same cycle → no push, and o_game_start stays 0.
   - A separate up press whose push cycle coincides with i_tick on an empty queue → count=1 and o_direction unchanged. The next tick gives UP.
6. **Reset mid-operation.** Assert i_reset while the queue holds 2 entries and a key is mid-debounce. Required: all outputs return to reset values, and releasing reset produces no spurious press event.
